btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter N_BTN, default 5, number of independent button channels (1..16).
REQ-002 Parameter DB_CYCLES, default 1_000_000, stable-sample cycles needed to accept a level change (10 ms at 100 MHz); minimum 2.
REQ-003 Parameter LONG_CYCLES, default 100_000_000, cycles of debounced-high needed for a long-press event; must exceed DB_CYCLES.
REQ-004 Port clk, input, 1, single system clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port btn_in, input, N_BTN, raw asynchronous button levels, 1 = pressed.
REQ-007 Port btn_level, output, N_BTN, debounced level per channel.
REQ-008 Port btn_rise, output, N_BTN, one-cycle pulse on each accepted press.
REQ-009 Port btn_fall, output, N_BTN, one-cycle pulse on each accepted release.
REQ-010 Port btn_long, output, N_BTN, one-cycle long-press pulse; present only per REQ-026.

Function
REQ-011 Each channel SHALL pass btn_in through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL run a 4-state FSM: REL (stable released), PRESS_WAIT, PRS (stable pressed), REL_WAIT.
REQ-013 REL -> PRESS_WAIT when the synchronized input is 1; PRS -> REL_WAIT when it is 0; the counter SHALL clear on each of these transitions.
REQ-014 In a WAIT state the counter SHALL increment each cycle the synchronized input holds the new value.
REQ-015 The FSM SHALL return to the prior stable state, with counter cleared and no output change, if the input reverts before the count completes.
REQ-016 When the counter reaches DB_CYCLES-1 with input still at the new value, the FSM SHALL enter the new stable state and update btn_level on that same edge.
REQ-017 For a clean step held long enough, btn_level SHALL change on the (DB_CYCLES+2)th rising edge after the step: 2 synchronizer edges plus DB_CYCLES count edges.
REQ-018 btn_rise and btn_fall SHALL be registered, asserted for exactly one cycle, and coincide with the cycle btn_level first shows the new value.
REQ-019 The counter width SHALL be clog2(LONG_CYCLES+1) bits; it SHALL saturate and never wrap.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-021 An input toggling every cycle SHALL never produce a pulse or change btn_level.

Reset
REQ-022 While reset is high, every FSM SHALL be in REL, all counters 0, all synchronizer flops 0.
REQ-023 While reset is high, btn_level, btn_rise, btn_fall and btn_long SHALL all be 0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort with no pulse emitted, including on the reset-release cycle.
REQ-025 A button held through reset release SHALL be treated as a new press: btn_rise fires DB_CYCLES+2 edges after reset deasserts.

Configuration
REQ-026 Macro BTN_LONGPRESS_EN defined: in PRS the counter SHALL keep counting from the press-accept cycle, and btn_long SHALL pulse once when the count reaches LONG_CYCLES-1 after acceptance. It SHALL not repeat until a release is accepted.
REQ-027 Macro BTN_LONGPRESS_EN undefined: the btn_long port SHALL be absent and the counter width SHALL be clog2(DB_CYCLES+1).

Structure
REQ-028 A shared package btn_debounce_pkg SHALL hold the FSM state encodings (2-bit) and the default DB_CYCLES and LONG_CYCLES constants.
REQ-029 The single-channel logic SHALL be a sub-module btn_debounce_ch, instantiated N_BTN times via a generate loop in btn_debounce.

Verification
Bench parameters for all scenarios: DB_CYCLES=4, LONG_CYCLES=20, N_BTN=5, 10 ns clock, reset high for 2 cycles.
REQ-030 Clean press: btn_in[0] 0->1 held -> btn_level[0]=1 and btn_rise[0]=1 for one cycle, on the 6th edge after the step.
REQ-031 Glitch: btn_in[1] high for 3 cycles then low -> btn_level[1] stays 0, no btn_rise; then a clean release of a pressed channel -> btn_fall fires once.
REQ-032 Simultaneous press: btn_in=5'b10101 in one step -> btn_rise=5'b10101 in the same single cycle.
REQ-033 Reset abort: press btn_in[2], assert reset at count 2 for 1 cycle, keep pressed -> no pulse during or at reset release; btn_rise[2] fires 6 edges after reset deasserts.
REQ-034 Long press (macro on): hold btn_in[3] -> btn_rise[3] at edge 6, btn_long[3] once 20 cycles later, no repeat.
REQ-035 Long press (macro off): same stimulus as REQ-034 -> btn_rise[3] at edge 6, no btn_long port exists.
REQ-036 Toggle-every-cycle on btn_in[4] for 50 cycles -> all outputs of channel 4 remain 0.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debouncer: per-channel FSM state
// encodings, default timing constants and counter sizing helpers.
package btn_debounce_pkg;

  // Per-channel debounce FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_REL        = 2'b00,  // stable released
    ST_PRESS_WAIT = 2'b01,  // saw a 1, qualifying the press
    ST_PRS        = 2'b11,  // stable pressed
    ST_REL_WAIT   = 2'b10   // saw a 0, qualifying the release
  } state_e;

  // 10 ms at 100 MHz.
  localparam int DB_CYCLES_DEF   = 1_000_000;
  // 1 s at 100 MHz.
  localparam int LONG_CYCLES_DEF = 100_000_000;

  // Largest value the shared counter must hold; the long-press timer
  // reuses the debounce counter, so it dominates when that feature is on.
  function automatic int cnt_max(input bit long_en, input int db_cycles,
                                 input int long_cycles);
    return long_en ? long_cycles : db_cycles;
  endfunction

  // Bits needed to hold 0..max_count without wrapping.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single debounced button channel: 2-flop synchronizer followed by a
// REL / PRESS_WAIT / PRS / REL_WAIT FSM with a saturating counter.
// Optional long-press detection is enabled with macro BTN_LONGPRESS_EN.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
`ifdef BTN_LONGPRESS_EN
  ,output logic long_o
`endif
);

`ifdef BTN_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int CNT_MAX = cnt_max(LONG_EN, DB_CYCLES, LONG_CYCLES);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  // The wait-state entry edge is the first qualifying sample, so the count
  // completes when the register already holds DB_CYCLES-2.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 2);
`ifdef BTN_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
`ifdef BTN_LONGPRESS_EN
  logic             long_q, long_d;
  logic             long_done_q, long_done_d;
`endif

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc_s = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_ONE);

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_REL;
      cnt_q       <= CNT_ZERO;
      level_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
`ifdef BTN_LONGPRESS_EN
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
`ifdef BTN_LONGPRESS_EN
      long_q      <= long_d;
      long_done_q <= long_done_d;
`endif
    end
  end

  // Next-state, counter and pulse decode from the synchronized level.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
`ifdef BTN_LONGPRESS_EN
    long_d      = 1'b0;
    long_done_d = long_done_q;
`endif
    case (state_q)
      ST_REL: begin
        cnt_d = CNT_ZERO;
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
        end else begin
          state_d = ST_REL;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          // Bounce: abandon the press silently.
          state_d = ST_REL;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_PRS;
          cnt_d   = CNT_ZERO;
          level_d = 1'b1;
          rise_d  = 1'b1;
`ifdef BTN_LONGPRESS_EN
          long_done_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_PRS: begin
        if (!sync2_q) begin
          state_d = ST_REL_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
`ifdef BTN_LONGPRESS_EN
          // Long-press timer runs from the accept edge; one pulse per press.
          if ((cnt_q == LONG_LAST) && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            long_d      = 1'b0;
          end
          cnt_d = cnt_inc_s;
`else
          cnt_d = CNT_ZERO;
`endif
        end
      end
      ST_REL_WAIT: begin
        if (sync2_q) begin
          // Bounce: stay pressed, restart counting.
          state_d = ST_PRS;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_REL;
          cnt_d   = CNT_ZERO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_REL;
        cnt_d   = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
`ifdef BTN_LONGPRESS_EN
  assign long_o  = long_q;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: N_BTN independent btn_debounce_ch
// instances. Define BTN_LONGPRESS_EN to add the btn_long pulse output.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall
`ifdef BTN_LONGPRESS_EN
  ,output logic [N_BTN-1:0] btn_long
`endif
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_in[g]),
      .level_o(btn_level[g]),
      .rise_o (btn_rise[g]),
      .fall_o (btn_fall[g])
`ifdef BTN_LONGPRESS_EN
      ,.long_o(btn_long[g])
`endif
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios with literal
// edge-by-edge expectations plus randomized stimulus compared every cycle
// against a sample-run behavioural model.
module tb_btn_debounce;

  localparam int N_BTN = 5;
  localparam int DB    = 4;
  localparam int LONG  = 20;

  logic             clk;
  logic             reset;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level, btn_rise, btn_fall;
  logic [N_BTN-1:0] btn_long_s;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .N_BTN      (N_BTN),
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
`ifdef BTN_LONGPRESS_EN
    ,.btn_long(btn_long_s)
`endif
  );

`ifndef BTN_LONGPRESS_EN
  assign btn_long_s = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each channel sees its raw input two edges late; a level change is
  // accepted once DB consecutive samples disagree with the current level.
  bit               m_s1[N_BTN];
  bit               m_s2[N_BTN];
  bit               m_lvl[N_BTN];
  int               m_run[N_BTN];
  int               m_lp[N_BTN];
  bit               m_fired[N_BTN];
  logic [N_BTN-1:0] e_level, e_rise, e_fall, e_long;
  bit               model_valid = 1'b0;

  always @(posedge clk) begin
    e_rise = '0;
    e_fall = '0;
    e_long = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (reset) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0;
        m_run[i] = 0; m_lp[i] = 0; m_fired[i] = 1'b0;
      end else begin
        bit sp;
        int run_old;
        sp      = m_s2[i];
        run_old = m_run[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = btn_in[i];
        if (sp != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i] = sp;
            m_run[i] = 0;
            if (sp) begin
              e_rise[i] = 1'b1; m_lp[i] = 0; m_fired[i] = 1'b0;
            end else begin
              e_fall[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
          if (m_lvl[i]) begin
            if (run_old > 0) begin
              m_lp[i] = 0;  // rejected release glitch restarts the hold timer
            end else begin
              if (m_lp[i] == LONG - 1 && !m_fired[i]) begin
                e_long[i] = 1'b1; m_fired[i] = 1'b1;
              end
              if (m_lp[i] < LONG) m_lp[i]++;
            end
          end
        end
      end
      e_level[i] = m_lvl[i];
    end
    model_valid = 1'b1;
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (btn_level !== e_level) begin
        errors++; $display("FAIL model_level: got %b expected %b at %0t", btn_level, e_level, $time);
      end
      checks++;
      if (btn_rise !== e_rise) begin
        errors++; $display("FAIL model_rise: got %b expected %b at %0t", btn_rise, e_rise, $time);
      end
      checks++;
      if (btn_fall !== e_fall) begin
        errors++; $display("FAIL model_fall: got %b expected %b at %0t", btn_fall, e_fall, $time);
      end
`ifdef BTN_LONGPRESS_EN
      checks++;
      if (btn_long_s !== e_long) begin
        errors++; $display("FAIL model_long: got %b expected %b at %0t", btn_long_s, e_long, $time);
      end
`endif
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  int hold[N_BTN];

  initial begin
    reset  = 1'b1;
    btn_in = '0;
    edge_settle();
    edge_settle();
    chk("reset_level", 32'(btn_level), 32'd0);
    chk("reset_rise",  32'(btn_rise),  32'd0);
    chk("reset_fall",  32'(btn_fall),  32'd0);
    chk("reset_long",  32'(btn_long_s), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press on channel 0: accepted on the 6th edge.
    btn_in[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      edge_settle();
      chk("press_level0", 32'(btn_level[0]), (e >= 6) ? 32'd1 : 32'd0);
      chk("press_rise0",  32'(btn_rise[0]),  (e == 6) ? 32'd1 : 32'd0);
    end

    // Glitch on channel 1: three cycles high is too short.
    @(negedge clk); btn_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn_in[1] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      edge_settle();
      chk("glitch_level1", 32'(btn_level[1]), 32'd0);
      chk("glitch_rise1",  32'(btn_rise[1]),  32'd0);
    end

    // Clean release of channel 0.
    @(negedge clk); btn_in[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      edge_settle();
      chk("release_level0", 32'(btn_level[0]), (e >= 6) ? 32'd0 : 32'd1);
      chk("release_fall0",  32'(btn_fall[0]),  (e == 6) ? 32'd1 : 32'd0);
    end

    // Simultaneous press and release on channels 0, 2, 4.
    @(negedge clk); btn_in = 5'b10101;
    for (int e = 1; e <= 7; e++) begin
      edge_settle();
      chk("simul_rise", 32'(btn_rise), (e == 6) ? 32'h15 : 32'h0);
    end
    @(negedge clk); btn_in = 5'b00000;
    for (int e = 1; e <= 7; e++) begin
      edge_settle();
      chk("simul_fall", 32'(btn_fall), (e == 6) ? 32'h15 : 32'h0);
    end

    // Reset abort on channel 2 at count 2, button kept pressed.
    @(negedge clk); btn_in[2] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    edge_settle();
    chk("abort_rise_in_reset",  32'(btn_rise),  32'd0);
    chk("abort_level_in_reset", 32'(btn_level), 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      edge_settle();
      chk("abort_rise2", 32'(btn_rise[2]), (e == 6) ? 32'd1 : 32'd0);
    end
    @(negedge clk); btn_in[2] = 1'b0;
    repeat (10) @(negedge clk);

    // Long hold on channel 3.
    btn_in[3] = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      edge_settle();
      chk("hold_rise3", 32'(btn_rise[3]), (e == 6) ? 32'd1 : 32'd0);
`ifdef BTN_LONGPRESS_EN
      chk("hold_long3", 32'(btn_long_s[3]), (e == 6 + LONG) ? 32'd1 : 32'd0);
`endif
    end
    @(negedge clk); btn_in[3] = 1'b0;
    repeat (10) @(negedge clk);

    // Toggle channel 4 every cycle.
    for (int e = 1; e <= 50; e++) begin
      @(negedge clk); btn_in[4] = ~btn_in[4];
      edge_settle();
      chk("toggle_ch4", {29'd0, btn_level[4], btn_rise[4], btn_fall[4]}, 32'd0);
    end
    @(negedge clk); btn_in[4] = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized hold lengths per channel, with rare resets.
    for (int i = 0; i < N_BTN; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_BTN; i++) begin
        if (hold[i] == 0) begin
          btn_in[i] = 1'($urandom_range(0, 1));
          hold[i]   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 45))
                                                  : int'($urandom_range(0, 6));
        end else begin
          hold[i]--;
        end
      end
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
